// File: rtl/uart_pkg.sv
// Shared types and helpers for the extended UART receiver.
package uart_pkg;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } state_t;

    // Parity checking mode after decoding the two-bit control field.
    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_t;

    // Widest data field the parity helper has to cover.
    localparam int PAR_MAX_W = 9;

    // 2-of-3 majority vote over the three samples of one bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // 00 and 11 both mean no parity.
    function automatic parity_t decode_parity(input logic [1:0] mode);
        parity_t res;
        case (mode)
            2'b01:   res = PAR_EVEN;
            2'b10:   res = PAR_ODD;
            default: res = PAR_NONE;
        endcase
        return res;
    endfunction

    // Parity error over data plus received parity bit; never set without parity.
    function automatic logic parity_fail(input parity_t mode,
                                         input logic [PAR_MAX_W-1:0] data,
                                         input logic pbit);
        logic ones_odd;
        logic res;
        ones_odd = ^{data, pbit};
        case (mode)
            PAR_EVEN: res = ones_odd;
            PAR_ODD:  res = ~ones_odd;
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uart_rx_ext_baud_gen.sv
// Oversampling tick generator: one tick every divisor+1 clocks.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // '>=' so a divisor that shrinks below the running count wraps at once.
    assign tick = (cnt >= divisor);

    // Free-running counter 0..divisor, cleared on the tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: synchroniser, oversampling FSM with 3-sample
// majority voting, false-start rejection, parity/framing checks and break
// detection.
// Output protocol: rx_done_tick is a one-cycle valid strobe with no ready;
// dout and the three flags are valid from that strobe and hold until the
// next strobe, so the consumer must take them within one frame time.
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int DBIT  = 8,
    parameter int OVS   = 16,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx,
    input  logic [DIV_W-1:0] divisor,
    input  logic [1:0]       parity_mode,
    input  logic             two_stop,
    output logic [DBIT-1:0]  dout,
    output logic             rx_done_tick,
    output logic             parity_err,
    output logic             frame_err,
    output logic             break_det,
    output logic             smpl_tick
);

    localparam int SW = $clog2(OVS);
    localparam int NW = $clog2(DBIT);
    // Decision points: middle of the start bit, then one full bit later.
    localparam logic [SW-1:0] K_START = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] K_BIT   = SW'(OVS - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

    // Synchroniser
    logic rx_meta, rx_sync;

    // FSM and datapath registers
    state_t            state, state_d;
    logic [SW-1:0]     s, s_d;
    logic [NW-1:0]     n, n_d;
    logic [DBIT-1:0]   shreg, shreg_d;
    logic              pbit, pbit_d;
    logic [1:0]        samp, samp_d;
    logic              stop_idx, stop_idx_d;
    logic              ferr_acc, ferr_acc_d;
    logic              all_zero, all_zero_d;
    parity_t           pmode_q, pmode_d;
    logic              two_q, two_d;
    logic [DIV_W-1:0]  div_q, div_d;

    // Registered outputs, next values
    logic [DBIT-1:0]   dout_d;
    logic              done_d, perr_d, ferr_d, brk_d, smpl_d;

    // Sampling helpers
    logic              tick;
    logic [DIV_W-1:0]  div_eff;
    logic [SW-1:0]     k, k_m1, k_m2;
    logic              sampling, decide, bit_v;
    logic              stop_low;

    // Live divisor while idle, the frame's latched copy once a start is seen.
    assign div_eff = (state == IDLE) ? divisor : div_q;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .divisor (div_eff),
        .tick    (tick)
    );

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    assign k        = (state == START) ? K_START : K_BIT;
    assign k_m1     = k - SW'(1);
    assign k_m2     = k - SW'(2);
    assign sampling = (state == START) || (state == DATA) ||
                      (state == PARITY) || (state == STOP);
    assign decide   = sampling && tick && (s == k);
    assign bit_v    = maj3(samp[0], samp[1], rx_sync);
    assign stop_low = ~bit_v;

    // Next-state, sample accumulation, shifting and completion outputs.
    always_comb begin
        state_d    = state;
        s_d        = s;
        n_d        = n;
        shreg_d    = shreg;
        pbit_d     = pbit;
        samp_d     = samp;
        stop_idx_d = stop_idx;
        ferr_acc_d = ferr_acc;
        all_zero_d = all_zero;
        pmode_d    = pmode_q;
        two_d      = two_q;
        div_d      = div_q;
        dout_d     = dout;
        perr_d     = parity_err;
        ferr_d     = frame_err;
        brk_d      = break_det;
        done_d     = 1'b0;
        smpl_d     = decide;

        // Collect the first two votes; the third is the live sample at k.
        if (sampling && tick) begin
            if (s == k_m2) samp_d[0] = rx_sync;
            if (s == k_m1) samp_d[1] = rx_sync;
            s_d = (s == k) ? '0 : s + 1'b1;
        end

        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_d = START;
                    s_d     = '0;
                    pmode_d = decode_parity(parity_mode);
                    two_d   = two_stop;
                    div_d   = divisor;
                end
            end
            START: begin
                if (decide) begin
                    if (bit_v) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = DATA;
                        n_d        = '0;
                        all_zero_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    shreg_d    = {bit_v, shreg[DBIT-1:1]};
                    all_zero_d = all_zero & ~bit_v;
                    if (n == N_LAST) begin
                        stop_idx_d = 1'b0;
                        ferr_acc_d = 1'b0;
                        state_d    = (pmode_q != PAR_NONE) ? PARITY : STOP;
                    end else begin
                        n_d = n + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (decide) begin
                    pbit_d     = bit_v;
                    all_zero_d = all_zero & ~bit_v;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    if (!stop_idx && all_zero && stop_low) begin
                        // Line held low through the whole frame: report a break.
                        done_d  = 1'b1;
                        dout_d  = '0;
                        ferr_d  = 1'b1;
                        perr_d  = 1'b0;
                        brk_d   = 1'b1;
                        state_d = BRK_WAIT;
                    end else if (two_q && !stop_idx) begin
                        ferr_acc_d = ferr_acc | stop_low;
                        stop_idx_d = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        dout_d  = shreg;
                        ferr_d  = ferr_acc | stop_low;
                        perr_d  = parity_fail(pmode_q, PAR_MAX_W'(shreg), pbit);
                        brk_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            BRK_WAIT: begin
                if (rx_sync) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            shreg        <= '0;
            pbit         <= 1'b0;
            samp         <= '0;
            stop_idx     <= 1'b0;
            ferr_acc     <= 1'b0;
            all_zero     <= 1'b0;
            pmode_q      <= PAR_NONE;
            two_q        <= 1'b0;
            div_q        <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            break_det    <= 1'b0;
            smpl_tick    <= 1'b0;
        end else begin
            state        <= state_d;
            s            <= s_d;
            n            <= n_d;
            shreg        <= shreg_d;
            pbit         <= pbit_d;
            samp         <= samp_d;
            stop_idx     <= stop_idx_d;
            ferr_acc     <= ferr_acc_d;
            all_zero     <= all_zero_d;
            pmode_q      <= pmode_d;
            two_q        <= two_d;
            div_q        <= div_d;
            dout         <= dout_d;
            rx_done_tick <= done_d;
            parity_err   <= perr_d;
            frame_err    <= ferr_d;
            break_det    <= brk_d;
            smpl_tick    <= smpl_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: directed scenarios plus randomised frames checked
// against a frame-level reference model.
module tb_uart_rx_ext;

  localparam int DBIT    = 8;
  localparam int OVS     = 16;
  localparam int DIV_W   = 16;
  localparam int BIT_CLK = 64;  // divisor 3 -> 4 clocks per tick, 16 ticks per bit

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             rx = 1'b1;
  logic [DIV_W-1:0] divisor = 16'd3;
  logic [1:0]       parity_mode = 2'b00;
  logic             two_stop = 1'b0;
  logic [DBIT-1:0]  dout;
  logic             rx_done_tick, parity_err, frame_err, break_det, smpl_tick;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int smpl_cnt = 0;
  int smpl_at_done = 0;
  int done_base = 0;
  int smpl_base = 0;
  logic [DBIT-1:0] cap_dout = '0;
  logic cap_perr = 1'b0, cap_ferr = 1'b0, cap_brk = 1'b0;

  // Scoreboard: expected {break, frame_err, parity_err, dout} and decision counts.
  logic [DBIT+2:0] exp_q[$];
  int              exp_smpl_q[$];

  uart_rx_ext #(.DBIT(DBIT), .OVS(OVS), .DIV_W(DIV_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .divisor      (divisor),
    .parity_mode  (parity_mode),
    .two_stop     (two_stop),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .break_det    (break_det),
    .smpl_tick    (smpl_tick)
  );

  // clock
  always #5 clk = ~clk;

  // monitor: count strobes and capture results at each completion
  always @(negedge clk) begin
    if (smpl_tick) smpl_cnt++;
    if (rx_done_tick) begin
      done_cnt++;
      smpl_at_done = smpl_cnt;
      cap_dout = dout;
      cap_perr = parity_err;
      cap_ferr = frame_err;
      cap_brk  = break_det;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Frame-level reference: break, framing and parity rules applied to the line fields.
  function automatic logic [DBIT+2:0] model(input logic [7:0] d, input logic [1:0] pm,
                                            input logic pb, input logic st1,
                                            input logic st2, input logic two);
    logic pen, ferr, perr;
    int ones;
    pen = (pm == 2'b01) || (pm == 2'b10);
    if (d == 8'h00 && (!pen || !pb) && !st1) return {1'b1, 1'b1, 1'b0, 8'h00};
    ferr = !st1 || (two && !st2);
    ones = $countones({d, (pen ? pb : 1'b0)});
    if (pm == 2'b01)      perr = (ones % 2) != 0;
    else if (pm == 2'b10) perr = (ones % 2) == 0;
    else                  perr = 1'b0;
    return {1'b0, ferr, perr, d};
  endfunction

  function automatic int model_smpl(input logic [7:0] d, input logic [1:0] pm,
                                    input logic pb, input logic st1,
                                    input logic st2, input logic two);
    logic [DBIT+2:0] r;
    int pen;
    r = model(d, pm, pb, st1, st2, two);
    pen = ((pm == 2'b01) || (pm == 2'b10)) ? 1 : 0;
    return 1 + DBIT + pen + ((r[DBIT+2] || !two) ? 1 : 2);
  endfunction

  // driver: one bit period, optional 2-clock inverted glitch, optional early release high
  task automatic drive_bit(input logic v, input int goff, input int hold);
    for (int c = 0; c < BIT_CLK; c++) begin
      @(negedge clk);
      if (c >= hold) rx = 1'b1;
      else if (goff >= 0 && c >= goff && c < goff + 2) rx = ~v;
      else rx = v;
    end
  endtask

  task automatic idle_bits(input int nb);
    for (int c = 0; c < nb * BIT_CLK; c++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // driver: a full frame; a low final stop bit is released early so the
  // line tail cannot be mistaken for a new start bit
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic pb,
                            input logic st1, input logic st2, input logic two,
                            input int gbit, input int goff, input logic scramble);
    logic pen;
    pen = (pm == 2'b01) || (pm == 2'b10);
    parity_mode = pm;
    two_stop = two;
    divisor = 16'd3;
    exp_q.push_back(model(d, pm, pb, st1, st2, two));
    exp_smpl_q.push_back(model_smpl(d, pm, pb, st1, st2, two));
    done_base = done_cnt;
    smpl_base = smpl_cnt;
    drive_bit(1'b0, -1, BIT_CLK);
    if (scramble) begin
      divisor = 16'($urandom_range(0, 40));
      parity_mode = 2'($urandom_range(0, 3));
      two_stop = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 8; i++) drive_bit(d[i], (gbit == i) ? goff : -1, BIT_CLK);
    if (pen) drive_bit(pb, -1, BIT_CLK);
    divisor = 16'd3;
    parity_mode = pm;
    two_stop = two;
    drive_bit(st1, -1, (!two && !st1) ? 44 : BIT_CLK);
    if (two) drive_bit(st2, -1, st2 ? BIT_CLK : 44);
    idle_bits(1);
  endtask

  // scoreboard: compare the completed frame against the head of the queue
  task automatic check_frame(input string tag);
    logic [DBIT+2:0] e;
    int es;
    @(negedge clk);
    #1;
    e = exp_q.pop_front();
    es = exp_smpl_q.pop_front();
    check({tag, ".done"}, done_cnt - done_base, 1);
    check({tag, ".dout"}, cap_dout, e[DBIT-1:0]);
    check({tag, ".perr"}, cap_perr, e[DBIT]);
    check({tag, ".ferr"}, cap_ferr, e[DBIT+1]);
    check({tag, ".brk"}, cap_brk, e[DBIT+2]);
    check({tag, ".smpl"}, smpl_at_done - smpl_base, es);
    check({tag, ".hold"}, dout, e[DBIT-1:0]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".dout"}, dout, 0);
    check({tag, ".done"}, rx_done_tick, 0);
    check({tag, ".perr"}, parity_err, 0);
    check({tag, ".ferr"}, frame_err, 0);
    check({tag, ".brk"}, break_det, 0);
    check({tag, ".smpl"}, smpl_tick, 0);
  endtask

  initial begin
    logic [7:0] rd;
    logic [1:0] rpm;
    logic rtwo, rpb, rst1, rst2;

    // reset
    repeat (4) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    reset_n = 1'b1;
    idle_bits(1);

    // 8N1 0xA5
    send_frame(8'hA5, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0);
    check_frame("8n1_a5");

    // 8E1 0x07 good parity, then bad parity
    send_frame(8'h07, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0);
    check_frame("8e1_good");
    send_frame(8'h07, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0);
    check_frame("8e1_bad");

    // glitch shorter than half a bit: rejected, one start decision only
    parity_mode = 2'b00;
    two_stop = 1'b0;
    done_base = done_cnt;
    smpl_base = smpl_cnt;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle_bits(3);
    #1;
    check("glitch.done", done_cnt - done_base, 0);
    check("glitch.smpl", smpl_cnt - smpl_base, 1);
    send_frame(8'h3C, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0);
    check_frame("after_glitch");

    // single corrupted sample in data bit 3
    send_frame(8'h55, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 3, 28, 1'b0);
    check_frame("noise_55");

    // 8N2 with second stop low
    send_frame(8'h81, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, -1, 0, 1'b0);
    check_frame("8n2_ferr");

    // reset for one clock in the middle of the data bits
    parity_mode = 2'b00;
    two_stop = 1'b0;
    done_base = done_cnt;
    drive_bit(1'b0, -1, BIT_CLK);
    drive_bit(1'b1, -1, BIT_CLK);
    drive_bit(1'b0, -1, BIT_CLK);
    drive_bit(1'b1, -1, BIT_CLK);
    @(negedge clk);
    reset_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    #1;
    check_outputs_zero("mid_reset");
    reset_n = 1'b1;
    idle_bits(3);
    check("mid_reset.no_done", done_cnt - done_base, 0);
    send_frame(8'h5A, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0);
    check_frame("after_reset");

    // break: line low for 12 bit times
    parity_mode = 2'b00;
    two_stop = 1'b0;
    done_base = done_cnt;
    smpl_base = smpl_cnt;
    for (int c = 0; c < 12 * BIT_CLK; c++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    #1;
    check("break.done", done_cnt - done_base, 1);
    check("break.dout", cap_dout, 0);
    check("break.ferr", cap_ferr, 1);
    check("break.brk", cap_brk, 1);
    check("break.perr", cap_perr, 0);
    check("break.smpl", smpl_at_done - smpl_base, 1 + DBIT + 1);
    idle_bits(2);
    check("break.release", done_cnt - done_base, 1);
    send_frame(8'hC3, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0);
    check_frame("after_break");

    // randomised frames with mid-frame configuration changes and glitches
    for (int f = 0; f < 12; f++) begin
      rd   = 8'($urandom_range(0, 255));
      rpm  = 2'($urandom_range(0, 3));
      rtwo = 1'($urandom_range(0, 1));
      rpb  = 1'($urandom_range(0, 1));
      rst1 = ($urandom_range(0, 3) != 0);
      rst2 = ($urandom_range(0, 3) != 0);
      if (f == 5) begin
        rd = 8'h00;
        rpb = 1'b0;
        rst1 = 1'b0;
      end
      send_frame(rd, rpm, rpb, rst1, rst2, rtwo,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 62)), 1'b1);
      check_frame("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
